sram_bus_responder: RTL and testbench

// Memory-side responder for the single-master CPU bus driven by the request unit.
// - Samples read_i/write_i/adr_i/cpu_dat_i/sel_i and services them from an internal word SRAM.
// - Byte-lane writes follow sel_i.
// - Signals occupancy on busy_o and returns read data on cpu_dat_o.
// - Fixed, parameterised access latency; one outstanding request at a time.

---
 rtl/sram_bus_responder_if.sv | 24 ++
 rtl/sram_bus_responder.sv | 156 +++++++++++++++
 tb/tb_sram_bus_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sram_bus_responder_if.sv
// Bus bundle between the CPU request unit (master) and the SRAM responder (slave).
interface sram_bus_responder_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    logic                  read_i;
    logic                  write_i;
    logic [ADDR_W-1:0]     adr_i;
    logic [DATA_W-1:0]     cpu_dat_i;
    logic [DATA_W/8-1:0]   sel_i;
    logic [DATA_W-1:0]     cpu_dat_o;
    logic                  busy_o;
    logic                  ack_o;

    modport master (
        output read_i, write_i, adr_i, cpu_dat_i, sel_i,
        input  cpu_dat_o, busy_o, ack_o
    );

    modport slave (
        input  read_i, write_i, adr_i, cpu_dat_i, sel_i,
        output cpu_dat_o, busy_o, ack_o
    );
endinterface

// File: rtl/sram_bus_responder.sv
// Single-outstanding SRAM responder: captures one request, waits a fixed latency,
// then commits the write or returns the read word and pulses ack.
module sram_bus_responder #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 32,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_bus_responder_if.slave    bus
);
    localparam int NB    = DATA_W / 8;
    localparam int MAX_L = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W = $clog2(MAX_L + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] RD_CNT_C = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_CNT_C = CNT_W'(WR_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [NB-1:0]       sel_q, sel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                commit_s;
    logic                in_range_s;
    logic [IDX_W-1:0]    idx_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     sel
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < NB; b++) begin
            if (sel[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Address decode of the captured request; out-of-range reads yield zero.
    always_comb begin
        in_range_s = ({1'b0, adr_q} < DEPTH_C);
        idx_s      = adr_q[IDX_W-1:0];
        if (in_range_s) begin
            rd_word_s = mem_q[idx_s];
        end else begin
            rd_word_s = '0;
        end
    end

    // Next-state logic: accept in IDLE (write wins), count down, then complete.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.write_i || bus.read_i) begin
                    adr_d = bus.adr_i;
                    dat_d = bus.cpu_dat_i;
                    sel_d = bus.sel_i;
                    if (bus.write_i) begin
                        state_d = ST_WRITE;
                        cnt_d   = WR_CNT_C;
                    end else begin
                        state_d = ST_READ;
                        cnt_d   = RD_CNT_C;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rdata_d = rd_word_s;
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    commit_s = in_range_s;
                    ack_d    = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control and output registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array: contents survive reset, byte lanes merged on commit.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_q[idx_s] <= merge_lanes(mem_q[idx_s], dat_q, sel_q);
        end
    end

    assign bus.cpu_dat_o = rdata_q;
    assign bus.busy_o    = busy_q;
    assign bus.ack_o     = ack_q;
endmodule

// File: tb/tb_sram_bus_responder.sv
// Directed and randomized bench for sram_bus_responder against a word-array reference model.
module tb_sram_bus_responder;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;

    sram_bus_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    sram_bus_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: byte-lane write or word read, out-of-range handled by the model.
    task automatic model_apply(input logic rd, input logic wr, input logic [4:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel);
        if (wr) begin
            if (adr < DEPTH) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel[b]) model_mem[adr][b*8 +: 8] = dat[b*8 +: 8];
                end
            end
        end else if (rd) begin
            model_rdata = (adr < DEPTH) ? model_mem[adr] : 32'd0;
        end
    endtask

    task automatic request(input logic rd, input logic wr, input logic [4:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, input string tag);
        int lat;
        bus_if.read_i    = rd;
        bus_if.write_i   = wr;
        bus_if.adr_i     = adr;
        bus_if.cpu_dat_i = dat;
        bus_if.sel_i     = sel;
        @(posedge clk); #1;
        bus_if.read_i    = 1'b0;
        bus_if.write_i   = 1'b0;
        bus_if.adr_i     = 5'($urandom);
        bus_if.cpu_dat_i = $urandom;
        bus_if.sel_i     = 4'($urandom);
        lat = wr ? WR_LAT : RD_LAT;
        for (int i = 0; i < lat; i++) begin
            check({tag, "_busy"}, 32'(bus_if.busy_o), 32'd1);
            check({tag, "_noack"}, 32'(bus_if.ack_o), 32'd0);
            @(posedge clk); #1;
        end
        model_apply(rd, wr, adr, dat, sel);
        check({tag, "_done_busy"}, 32'(bus_if.busy_o), 32'd0);
        check({tag, "_ack"}, 32'(bus_if.ack_o), 32'd1);
        check({tag, "_data"}, bus_if.cpu_dat_o, model_rdata);
        @(posedge clk); #1;
        check({tag, "_ack_clear"}, 32'(bus_if.ack_o), 32'd0);
        check({tag, "_idle"}, 32'(bus_if.busy_o), 32'd0);
    endtask

    initial begin
        logic [31:0] saved;
        checks = 0;
        errors = 0;
        model_rdata = 32'd0;
        rst = 1'b0;
        bus_if.read_i = 1'b0;
        bus_if.write_i = 1'b0;
        bus_if.adr_i = 5'd0;
        bus_if.cpu_dat_i = 32'd0;
        bus_if.sel_i = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus_if.busy_o), 32'd0);
        check("rst_ack", 32'(bus_if.ack_o), 32'd0);
        check("rst_dat", bus_if.cpu_dat_o, 32'd0);
        @(negedge clk) rst = 1'b1;

        for (int a = 0; a < DEPTH; a++) request(1'b0, 1'b1, 5'(a), $urandom, 4'hF, "init");

        // Plain write then read-back
        request(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 4'hF, "t1_wr");
        request(1'b1, 1'b0, 5'd3, 32'd0, 4'h0, "t1_rd");
        check("t1_const", bus_if.cpu_dat_o, 32'hDEADBEEF);

        // Partial byte-lane write
        request(1'b0, 1'b1, 5'd5, 32'h11223344, 4'hF, "t2_wr0");
        request(1'b0, 1'b1, 5'd5, 32'hAABBCCDD, 4'b0101, "t2_wr1");
        request(1'b1, 1'b0, 5'd5, 32'd0, 4'h0, "t2_rd");
        check("t2_const", bus_if.cpu_dat_o, 32'h11BB33DD);

        // Both strobes: write wins, read data untouched
        saved = bus_if.cpu_dat_o;
        request(1'b1, 1'b1, 5'd7, 32'h00000055, 4'hF, "t3_both");
        check("t3_dat_kept", bus_if.cpu_dat_o, saved);
        request(1'b1, 1'b0, 5'd7, 32'd0, 4'h0, "t3_rd");
        check("t3_const", bus_if.cpu_dat_o, 32'h00000055);

        // Held read with address stepping: accept every RD_LAT+1 cycles
        bus_if.read_i = 1'b1;
        bus_if.adr_i  = 5'd0;
        @(posedge clk); #1;
        check("t4_busy0", 32'(bus_if.busy_o), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            bus_if.adr_i = (c == 3) ? 5'd1 : (c == 6) ? 5'd2 : 5'($urandom_range(3, 31));
            @(posedge clk); #1;
            check("t4_busy", 32'(bus_if.busy_o), (c % 3 != 2) ? 32'd1 : 32'd0);
            check("t4_ack", 32'(bus_if.ack_o), (c % 3 == 2) ? 32'd1 : 32'd0);
            if (c % 3 == 2) begin
                model_rdata = model_mem[c / 3];
                check("t4_data", bus_if.cpu_dat_o, model_rdata);
            end
        end
        bus_if.read_i = 1'b0;
        @(posedge clk); #1;
        check("t4_idle", 32'(bus_if.busy_o), 32'd0);

        // Reset during a write aborts it
        bus_if.write_i   = 1'b1;
        bus_if.adr_i     = 5'd9;
        bus_if.cpu_dat_i = ~model_mem[9];
        bus_if.sel_i     = 4'hF;
        @(posedge clk); #1;
        bus_if.write_i = 1'b0;
        check("t5_busy", 32'(bus_if.busy_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_busy", 32'(bus_if.busy_o), 32'd0);
        check("t5_rst_ack", 32'(bus_if.ack_o), 32'd0);
        check("t5_rst_dat", bus_if.cpu_dat_o, 32'd0);
        model_rdata = 32'd0;
        @(posedge clk); #1;
        check("t5_no_ack", 32'(bus_if.ack_o), 32'd0);
        @(negedge clk) rst = 1'b1;
        request(1'b1, 1'b0, 5'd9, 32'd0, 4'h0, "t5_rd");

        // Out-of-range accesses and empty byte enable
        request(1'b1, 1'b0, 5'd3, 32'd0, 4'h0, "t6_pre");
        request(1'b1, 1'b0, 5'd20, 32'd0, 4'h0, "t6_rd_oor");
        check("t6_oor_zero", bus_if.cpu_dat_o, 32'd0);
        request(1'b0, 1'b1, 5'd20, 32'hCAFEF00D, 4'hF, "t6_wr_oor");
        request(1'b1, 1'b0, 5'd4, 32'd0, 4'h0, "t6_rd4");
        request(1'b0, 1'b1, 5'd6, 32'h12345678, 4'h0, "sel0_wr");
        request(1'b1, 1'b0, 5'd6, 32'd0, 4'h0, "sel0_rd");

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            int op;
            op = $urandom_range(0, 2);
            request((op != 1) ? 1'b1 : 1'b0, (op != 0) ? 1'b1 : 1'b0,
                    5'($urandom), $urandom, 4'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
